pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the multicycle MIPS datapath.
- Holds PC and computes next-PC for sequential, branch, jump, jump-register, return, external-load, exception and ERET flows.
- Captures EPC on traps and runs a small run/halt/trap state machine.
- Sits between the control FSM (issues WE plus mode) and instruction-memory address.

Parameters:
- WIDTH, 32, PC/data width; must be >= 32.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on any trap.
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN); power of two, >= 2.

Ports:
- CLK  in  1  clock; all state updates on falling edge.
- RST  in  1  asynchronous active-high reset.
- WE  in  1  commit next-PC this cycle.
- Mode  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 JR, 4 RET, 5 LOAD, 6/7 reserved.
- Imm16  in  16  branch offset in words.
- Target26  in  26  J-type target field.
- RegTarget  in  WIDTH  rs value for JR/RET.
- LoadValue  in  WIDTH  external PC value for LOAD.
- Link  in  1  with WE and Mode JUMP/JR: push PC+4 onto RAS.
- Exception  in  1  synchronous trap request.
- Eret  in  1  return from trap.
- Halt  in  1  request halt.
- DataOut  out  WIDTH  current PC.
- PCPlus4  out  WIDTH  DataOut+4, combinational.
- EPC  out  WIDTH  exception PC.
- Halted  out  1  high in HALTED.
- Misaligned  out  1  pulse: last accepted target had nonzero [1:0].

Behaviour:
- Reset (async, any time, incl. mid-trap):
  - DataOut=RESET_VECTOR, EPC=0, Halted=0, Misaligned=0.
  - RAS empty; state RUN.
- Next-PC arithmetic, modulo 2^WIDTH, wraps silently:
  - SEQ: PC+4.
  - BRANCH: PC+4+(sext(Imm16)<<2).
  - JUMP: {PCPlus4[WIDTH-1:28],Target26,2'b00}.
  - JR: RegTarget.
  - LOAD: LoadValue.
  - RET: RAS top if PC_RAS_EN and RAS nonempty, else RegTarget.
  - Reserved modes: behave as SEQ.
- States: RUN, HALTED, TRAP.
- RUN, per falling edge; priority Exception > Eret > Halt > WE:
  - Exception: EPC<=DataOut, DataOut<=EXC_VECTOR, go TRAP.
  - Eret in RUN: ignored (no update).
  - Halt: go HALTED; PC unchanged.
  - WE: candidate = next-PC.
    - Candidate[1:0]!=0: treat as Exception; EPC<=DataOut, DataOut<=EXC_VECTOR, Misaligned pulses one cycle, go TRAP.
    - Otherwise: DataOut<=candidate.
  - No request: hold.
- TRAP (handler running):
  - WE updates PC as in RUN.
  - Eret: DataOut<=EPC, go RUN.
  - Nested Exception: EXC_VECTOR reloaded; EPC NOT overwritten.
  - Halt ignored.
- HALTED: PC frozen; WE, Halt, Eret ignored. Exit only by Exception (normal trap entry) or reset.
- Latency: DataOut reflects a request one falling edge after it is sampled; PCPlus4 tracks combinationally.

Optional Feature:
- PC_RAS_EN defined: RAS_DEPTH-entry return-address stack.
  - Push on WE & Link & (Mode JUMP|JR), value PC+4; full: oldest entry dropped (circular overwrite).
  - Pop on WE & Mode RET in RUN/TRAP; empty: falls back to RegTarget, no underflow.
  - Push and pop never coincide (different modes).
  - Trap entry leaves RAS intact.
- PC_RAS_EN undefined: no stack storage; Link ignored; RET identical to JR.

Decomposition:
- Shared package pc_pkg: Mode encodings (PC_SEQ..PC_LOAD), state encodings, default vectors.
- One natural sub-module: pc_ras (circular LIFO with push/pop/top/empty), instantiated only under PC_RAS_EN.

Test Plan:
- Reset then WE+SEQ x3 -> DataOut 0,4,8,12; assert RST mid-stream -> DataOut immediately 0.
- PC=0x100, BRANCH Imm16=0xFFFF -> 0x100; Imm16=0x0010 -> 0x144; JUMP Target26=0x0000040 at PC=0x1000_0000 -> 0x1000_0100.
- JR RegTarget=0x202 -> DataOut=0x80, EPC=old PC, Misaligned one-cycle pulse; Eret -> DataOut=EPC, state RUN.
- Exception in TRAP -> DataOut 0x80, EPC unchanged; Exception+WE same cycle in RUN -> trap wins.
- Halt then WE+SEQ x5 -> PC frozen, Halted=1; Exception -> DataOut 0x80, Halted=0.
- PC_RAS_EN, depth 4: five linked JUMPs from PCs 0x0,0x10,0x20,0x30,0x40 -> RETs return 0x44,0x34,0x24,0x14, then RegTarget fallback.

Source files
------------

// File: rtl/pc_pkg.sv
// ============================================================================
// pc_pkg : shared mode/state encodings and default vectors for pc_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_JR     = 3'd3,
    PC_RET    = 3'd4,
    PC_LOAD   = 3'd5
  } pc_mode_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_TRAP   = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// pc_ras : circular return-address stack; a push when full drops the oldest
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW:0]      cnt_q, cnt_d;

  // ptr_q points at the next free slot; the pointer wraps so the oldest
  // entry is overwritten naturally once the stack is full
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + 1'b1;
      if (cnt_q != (PW+1)'(DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(negedge clk_i) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

  assign top_o   = mem_q[ptr_q - 1'b1];
  assign empty_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// pc_unit : program counter with next-PC selection, EPC capture and a
//           run/halt/trap FSM; PC_RAS_EN adds a return-address stack
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_DEF_EXC_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [2:0]       Mode,
  input  logic [15:0]      Imm16,
  input  logic [25:0]      Target26,
  input  logic [WIDTH-1:0] RegTarget,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             Link,
  input  logic             Exception,
  input  logic             Eret,
  input  logic             Halt,
  output logic [WIDTH-1:0] DataOut,
  output logic [WIDTH-1:0] PCPlus4,
  output logic [WIDTH-1:0] EPC,
  output logic             Halted,
  output logic             Misaligned
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             mis_q, mis_d;
  pc_state_e        state_q, state_d;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] ret_target;
  logic [WIDTH-1:0] cand;
  logic             commit;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign br_off   = {{(WIDTH-18){Imm16[15]}}, Imm16, 2'b00};

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_push, ras_pop;

  // Stack only moves when the candidate is actually committed
  assign ras_push = commit && Link && ((Mode == PC_JUMP) || (Mode == PC_JR));
  assign ras_pop  = commit && (Mode == PC_RET);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

  assign ret_target = ras_empty ? RegTarget : ras_top;
`else
  logic link_unused;
  assign link_unused = Link;
  assign ret_target  = RegTarget;
`endif

  always_comb begin
    cand = pc_plus4;
    case (Mode)
      PC_BRANCH: cand = pc_plus4 + br_off;
      PC_JUMP:   cand = {pc_plus4[WIDTH-1:28], Target26, 2'b00};
      PC_JR:     cand = RegTarget;
      PC_RET:    cand = ret_target;
      PC_LOAD:   cand = LoadValue;
      default:   cand = pc_plus4;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    mis_d   = 1'b0;
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (Exception) begin
          epc_d   = pc_q;
          pc_d    = EXC_VECTOR;
          state_d = ST_TRAP;
        end else if (!Eret) begin
          if (Halt) begin
            state_d = ST_HALTED;
          end else if (WE) begin
            if (cand[1:0] != 2'b00) begin
              epc_d   = pc_q;
              pc_d    = EXC_VECTOR;
              mis_d   = 1'b1;
              state_d = ST_TRAP;
            end else begin
              pc_d   = cand;
              commit = 1'b1;
            end
          end
        end
      end
      ST_TRAP: begin
        // Nested traps keep the original EPC so the handler can still return
        if (Exception) begin
          pc_d = EXC_VECTOR;
        end else if (Eret) begin
          pc_d    = epc_q;
          state_d = ST_RUN;
        end else if (WE) begin
          if (cand[1:0] != 2'b00) begin
            pc_d  = EXC_VECTOR;
            mis_d = 1'b1;
          end else begin
            pc_d   = cand;
            commit = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        if (Exception) begin
          epc_d   = pc_q;
          pc_d    = EXC_VECTOR;
          state_d = ST_TRAP;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      mis_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
      state_q <= state_d;
    end
  end

  assign DataOut    = pc_q;
  assign PCPlus4    = pc_plus4;
  assign EPC        = epc_q;
  assign Halted     = (state_q == ST_HALTED);
  assign Misaligned = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// tb_pc_unit : directed self-checking bench for pc_unit with a result queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  Mode = 3'd0;
  logic [15:0] Imm16 = '0;
  logic [25:0] Target26 = '0;
  logic [31:0] RegTarget = '0;
  logic [31:0] LoadValue = '0;
  logic        Link = 1'b0;
  logic        Exception = 1'b0;
  logic        Eret = 1'b0;
  logic        Halt = 1'b0;
  logic [31:0] DataOut, PCPlus4, EPC;
  logic        Halted, Misaligned;

  pc_unit dut (
    .CLK(CLK), .RST(RST), .WE(WE), .Mode(Mode), .Imm16(Imm16),
    .Target26(Target26), .RegTarget(RegTarget), .LoadValue(LoadValue),
    .Link(Link), .Exception(Exception), .Eret(Eret), .Halt(Halt),
    .DataOut(DataOut), .PCPlus4(PCPlus4), .EPC(EPC), .Halted(Halted),
    .Misaligned(Misaligned)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic compare_front();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard: observed empty queue expected entry");
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("s%0d.pc", e.id),     DataOut,             e.pc);
    chk($sformatf("s%0d.pc4", e.id),    PCPlus4,             e.pc + 32'd4);
    chk($sformatf("s%0d.epc", e.id),    EPC,                 e.epc);
    chk($sformatf("s%0d.halted", e.id), {31'd0, Halted},     {31'd0, e.halted});
    chk($sformatf("s%0d.mis", e.id),    {31'd0, Misaligned}, {31'd0, e.mis});
  endtask

  // Called at a rising edge: drive, let the falling edge commit, check at next rise
  task automatic step(input logic we, input logic [2:0] md, input logic [15:0] imm,
                      input logic [25:0] t26, input logic [31:0] rt, input logic [31:0] lv,
                      input logic lk, input logic exc, input logic er, input logic hl,
                      input logic [31:0] e_pc, input logic [31:0] e_epc,
                      input logic e_h, input logic e_m);
    exp_t e;
    WE = we; Mode = md; Imm16 = imm; Target26 = t26; RegTarget = rt; LoadValue = lv;
    Link = lk; Exception = exc; Eret = er; Halt = hl;
    step_id++;
    e.id = step_id; e.pc = e_pc; e.epc = e_epc; e.halted = e_h; e.mis = e_m;
    exp_q.push_back(e);
    @(posedge CLK);
    compare_front();
  endtask

  task automatic seq(input logic [31:0] e_pc, input logic [31:0] e_epc, input logic e_h);
    step(1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, e_pc, e_epc, e_h, 0);
  endtask

  task automatic load(input logic [31:0] v, input logic [31:0] e_epc);
    step(1, 3'd5, 0, 0, 0, v, 0, 0, 0, 0, v, e_epc, 0, 0);
  endtask

  // Async reset mid-cycle: DataOut must drop before any clock edge
  task automatic do_reset();
    exp_t e;
    WE = 0; Mode = 0; Link = 0; Exception = 0; Eret = 0; Halt = 0;
    #2 RST = 1'b1;
    #1;
    step_id++;
    e.id = step_id; e.pc = 32'h0; e.epc = 32'h0; e.halted = 1'b0; e.mis = 1'b0;
    exp_q.push_back(e);
    compare_front();
    @(posedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    logic [31:0] ret_exp [5];
    #1 RST = 1'b1;
    @(posedge CLK);
    begin
      exp_t e;
      e.id = 0; e.pc = 32'h0; e.epc = 32'h0; e.halted = 1'b0; e.mis = 1'b0;
      exp_q.push_back(e);
      compare_front();
    end
    RST = 1'b0;

    seq(32'h4, 0, 0);
    seq(32'h8, 0, 0);
    seq(32'hC, 0, 0);
    do_reset();

    load(32'h100, 0);
    step(1, 3'd1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0);
    step(1, 3'd1, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 32'h144, 0, 0, 0);
    load(32'h1000_0000, 0);
    step(1, 3'd2, 0, 26'h40, 0, 0, 0, 0, 0, 0, 32'h1000_0100, 0, 0, 0);

    // Misaligned JR traps; then WE inside the handler, nested trap, ERET
    step(1, 3'd3, 0, 0, 32'h202, 0, 0, 0, 0, 0, 32'h80, 32'h1000_0100, 0, 1);
    seq(32'h84, 32'h1000_0100, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h80, 32'h1000_0100, 0, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1000_0100, 32'h1000_0100, 0, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1000_0100, 32'h1000_0100, 0, 0);
    step(1, 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h80, 32'h1000_0100, 0, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1000_0100, 32'h1000_0100, 0, 0);

    load(32'hFFFF_FFFC, 32'h1000_0100);
    seq(32'h0, 32'h1000_0100, 0);

    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h1000_0100, 1, 0);
    for (int i = 0; i < 5; i++) seq(32'h0, 32'h1000_0100, 1);
    step(1, 3'd0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h1000_0100, 1, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h80, 32'h0, 0, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 32'h0, 0, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0, 0);

    step(1, 3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 0, 0);
    step(1, 3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 32'h0, 0, 0);
    step(1, 3'd5, 0, 0, 0, 32'h3, 0, 0, 0, 0, 32'h80, 32'h8, 0, 1);
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8, 32'h8, 0, 0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      load(32'h10 * i, 0);
      step(1, 3'd2, 0, 26'h100, 0, 0, 1, 0, 0, 0, 32'h400, 0, 0, 0);
    end
`ifdef PC_RAS_EN
    ret_exp[0] = 32'h44; ret_exp[1] = 32'h34; ret_exp[2] = 32'h24;
    ret_exp[3] = 32'h14; ret_exp[4] = 32'h800;
`else
    for (int i = 0; i < 5; i++) ret_exp[i] = 32'h800;
`endif
    for (int i = 0; i < 5; i++)
      step(1, 3'd4, 0, 0, 32'h800, 0, 0, 0, 0, 0, ret_exp[i], 0, 0, 0);
    step(1, 3'd4, 0, 0, 32'h900, 0, 0, 0, 0, 0, 32'h900, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
